aes_serial_io_ctrl: RTL and testbench

- Sequencing controller for the serial I/O path of the AES-128 core.
- Steers a 1-bit host stream into two external 128-bit serial-in/parallel-out registers: key first, then plaintext.
- Pulses the core start, waits for done with a timeout, then drives an external parallel-in/serial-out ciphertext register back out to the host.
- Sits between the host serial pins and the SIPO/core/PISO datapath. Contains no data storage itself.

---
 rtl/aes_serial_io_ctrl.sv | 89 ++++++++
 tb/tb_aes_serial_io_ctrl.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/aes_serial_io_ctrl.sv
// aes_serial_io_ctrl: sequences host bits into key/plaintext SIPOs, runs the core, shifts ciphertext back out.
// Optional key reuse (skip LOAD_KEY) is enabled by defining AES_KEY_REUSE_EN.
module aes_serial_io_ctrl #(
  parameter int NBITS   = 128,
  parameter int TIMEOUT = 64
) (
  input  logic clk,
  input  logic reset,
  input  logic frame_start,
`ifdef AES_KEY_REUSE_EN
  input  logic key_reuse,
`endif
  input  logic in_valid,
  output logic in_ready,
  output logic key_wr_en,
  output logic pt_wr_en,
  output logic aes_start,
  input  logic aes_done,
  output logic ct_load,
  output logic ct_shift_en,
  output logic out_valid,
  input  logic out_ready,
  output logic busy,
  output logic frame_done,
  output logic err
);
  localparam int CW = $clog2(NBITS);
  localparam int TW = TIMEOUT > 1 ? $clog2(TIMEOUT) : 1;
  typedef enum logic [2:0] {IDLE, LOAD_KEY, LOAD_PT, START, WAIT, CT_LOAD, SHIFT, DONE} state_t;
  state_t state, state_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic [TW-1:0] tcnt, tcnt_nx;
  logic err_nx, reuse, last;
`ifdef AES_KEY_REUSE_EN
  assign reuse = key_reuse;
`else
  assign reuse = 1'b0;
`endif
  assign in_ready    = state == LOAD_KEY || state == LOAD_PT;
  assign key_wr_en   = in_valid && state == LOAD_KEY;
  assign pt_wr_en    = in_valid && state == LOAD_PT;
  assign aes_start   = state == START;
  assign ct_load     = state == CT_LOAD;
  assign out_valid   = state == SHIFT;
  assign ct_shift_en = out_valid && out_ready;
  assign busy        = state != IDLE;
  assign frame_done  = state == DONE;
  assign last        = cnt == CW'(NBITS - 1);
  always_comb begin
    state_nx = state;
    cnt_nx   = (key_wr_en || pt_wr_en || ct_shift_en) ? cnt + 1'b1 : cnt;
    tcnt_nx  = tcnt;
    err_nx   = err;
    case (state)
      IDLE: if (frame_start) begin
        state_nx = reuse ? LOAD_PT : LOAD_KEY;
        cnt_nx   = '0;
        err_nx   = 1'b0;
      end
      LOAD_KEY: state_nx = in_valid && last ? LOAD_PT : state;
      LOAD_PT:  state_nx = in_valid && last ? START : state;
      START: begin
        tcnt_nx  = '0;
        state_nx = WAIT;
      end
      // a done arriving on the final timeout cycle still completes the frame
      WAIT: if (aes_done) state_nx = CT_LOAD;
        else if (tcnt == TW'(TIMEOUT - 1)) begin
          err_nx   = 1'b1;
          state_nx = IDLE;
        end else tcnt_nx = tcnt + 1'b1;
      CT_LOAD: state_nx = SHIFT;
      SHIFT:   state_nx = out_ready && last ? DONE : state;
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
      tcnt  <= '0;
      err   <= 1'b0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      tcnt  <= tcnt_nx;
      err   <= err_nx;
    end
endmodule

// File: tb/tb_aes_serial_io_ctrl.sv
// tb_aes_serial_io_ctrl: directed frames checked against a beat-counting reference model every cycle.
module tb_aes_serial_io_ctrl;
  localparam int NB = 128, TO = 64;
  logic clk = 0, reset = 1, frame_start = 0, in_valid = 0, aes_done = 0, out_ready = 0;
`ifdef AES_KEY_REUSE_EN
  logic key_reuse = 0;
`endif
  logic in_ready, key_wr_en, pt_wr_en, aes_start, ct_load, ct_shift_en, out_valid, busy, frame_done, err;
  int checks = 0, errors = 0;
  int c_key, c_pt, c_start, c_load, c_shift, c_fd;
  time t_s, t_e;
  logic err_q = 0;
  always #5 clk = ~clk;
  aes_serial_io_ctrl #(.NBITS(NB), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .frame_start(frame_start),
`ifdef AES_KEY_REUSE_EN
    .key_reuse(key_reuse),
`endif
    .in_valid(in_valid), .in_ready(in_ready), .key_wr_en(key_wr_en), .pt_wr_en(pt_wr_en),
    .aes_start(aes_start), .aes_done(aes_done), .ct_load(ct_load), .ct_shift_en(ct_shift_en),
    .out_valid(out_valid), .out_ready(out_ready), .busy(busy), .frame_done(frame_done), .err(err));
  // model phases: 0 idle, 1 key, 2 pt, 3 start, 4 wait, 5 ct load, 6 shift, 7 done
  int m_phase = 0, m_left = NB, m_wait = 0;
  bit m_err = 0;
  always @(posedge clk or posedge reset)
    if (reset) begin
      m_phase = 0; m_left = NB; m_wait = 0; m_err = 0;
    end else if (m_phase == 0) begin
      if (frame_start) begin
`ifdef AES_KEY_REUSE_EN
        m_phase = key_reuse ? 2 : 1;
`else
        m_phase = 1;
`endif
        m_left = NB; m_err = 0;
      end
    end else if (m_phase == 1 || m_phase == 2) begin
      if (in_valid) begin
        m_left--;
        if (m_left == 0) begin m_phase++; m_left = NB; end
      end
    end else if (m_phase == 3) begin
      m_phase = 4; m_wait = 0;
    end else if (m_phase == 4) begin
      m_wait++;
      if (aes_done) m_phase = 5;
      else if (m_wait == TO) begin m_err = 1; m_phase = 0; end
    end else if (m_phase == 5) begin
      m_phase = 6; m_left = NB;
    end else if (m_phase == 6) begin
      if (out_ready) begin
        m_left--;
        if (m_left == 0) m_phase = 7;
      end
    end else m_phase = 0;
  always @(negedge clk) begin
    logic [9:0] e, a;
    e = {m_phase == 1 || m_phase == 2, in_valid && m_phase == 1, in_valid && m_phase == 2, m_phase == 3,
         m_phase == 5, out_ready && m_phase == 6, m_phase == 6, m_phase != 0, m_phase == 7, m_err};
    a = {in_ready, key_wr_en, pt_wr_en, aes_start, ct_load, ct_shift_en, out_valid, busy, frame_done, err};
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL cycle_outputs t=%0t got %b expected %b (rdy,key,pt,start,load,shift,ov,busy,fd,err)", $time, a, e);
    end
    c_key += int'(key_wr_en); c_pt += int'(pt_wr_en); c_start += int'(aes_start);
    c_load += int'(ct_load); c_shift += int'(ct_shift_en); c_fd += int'(frame_done);
    if (aes_start) t_s = $time;
    if (err && !err_q) t_e = $time;
    err_q <= err;
  end
  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", name, act, exp);
    end
  endtask
  task automatic step();
    @(posedge clk); #1;
  endtask
  task automatic run_frame(input bit reuse, input bit stall_in, input bit stall_out, input int done_delay, input bit inject);
    bit ok;
    c_key = 0; c_pt = 0; c_start = 0; c_load = 0; c_shift = 0; c_fd = 0;
`ifdef AES_KEY_REUSE_EN
    key_reuse = reuse;
`endif
    frame_start = 1;
    step();
    frame_start = 0;
    @(negedge clk);
    chk("err_cleared_on_start", int'(err), 0);
    chk("busy_after_start", int'(busy), 1);
    ok = 0;
    for (int k = 0; k < 3000 && !ok; k++) begin
      in_valid = stall_in ? (k % 2 == 1) : 1'b1;
      frame_start = inject && c_pt == 5;
      step();
      ok = c_start > 0;
    end
    in_valid = 0; frame_start = 0;
    chk("load_reached_start", int'(ok), 1);
    chk("key_beats", c_key, reuse ? 0 : NB);
    chk("pt_beats", c_pt, NB);
    chk("start_pulses", c_start, 1);
    if (done_delay < 0) begin
      ok = 0;
      for (int k = 0; k < 200 && !ok; k++) begin step(); ok = err_q; end
      chk("timeout_err_seen", int'(ok), 1);
      chk("timeout_cycles_from_start", int'((t_e - t_s) / 10), TO + 1);
      chk("timeout_no_ct_load", c_load, 0);
      chk("timeout_no_frame_done", c_fd, 0);
      @(negedge clk);
      chk("timeout_idle", int'(busy), 0);
      chk("timeout_err_sticky", int'(err), 1);
      return;
    end
    repeat (done_delay) step();
    aes_done = 1;
    step();
    aes_done = 0;
    ok = 0;
    for (int k = 0; k < 3000 && !ok; k++) begin
      out_ready = stall_out ? (k % 2 == 0) : 1'b1;
      aes_done = inject && c_shift == 3;
      step();
      ok = c_fd > 0;
    end
    out_ready = 0; aes_done = 0;
    chk("frame_done_seen", int'(ok), 1);
    chk("ct_load_pulses", c_load, 1);
    chk("shift_beats", c_shift, NB);
    chk("frame_done_pulses", c_fd, 1);
    @(negedge clk);
    chk("idle_after_frame", int'(busy), 0);
  endtask
  initial begin
    repeat (5) begin
      frame_start = 1'($urandom); in_valid = 1'($urandom); aes_done = 1'($urandom); out_ready = 1'($urandom);
      step();
    end
    frame_start = 0; in_valid = 0; aes_done = 0; out_ready = 0;
    reset = 0;
    @(negedge clk);
    chk("reset_busy", int'(busy), 0);
    chk("reset_err", int'(err), 0);
    step();
    run_frame(0, 0, 0, 10, 0);
    run_frame(0, 1, 1, 3, 0);
    run_frame(0, 0, 0, -1, 0);
    run_frame(0, 0, 0, 0, 1);
    frame_start = 1;
    step();
    frame_start = 0;
    c_key = 0;
    in_valid = 1;
    for (int k = 0; k < 500 && c_key < 70; k++) step();
    chk("mid_reset_beats", c_key, 70);
    reset = 1; in_valid = 0;
    step();
    reset = 0;
    @(negedge clk);
    chk("mid_reset_idle", int'(busy), 0);
    step();
    run_frame(0, 0, 0, TO - 1, 0);
`ifdef AES_KEY_REUSE_EN
    run_frame(1, 0, 0, 2, 0);
    run_frame(0, 0, 0, 2, 0);
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
